// File: rtl/pwm_duty_decoder.sv
// PWM receive decoder: synchronises pwm_in, measures high time and rise-to-rise period,
// and reports duty in tenths through a fixed 3-stage compute pipeline, or a stuck-line report.
module pwm_duty_decoder #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 2**CNT_W - 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_in,
    output logic [3:0]       duty_tenths,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             stuck
);
    localparam int PW = CNT_W + 4;
    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    // Constant multiply built from shifted copies of x, one per set bit of k.
    function automatic logic [PW-1:0] mul_k(input logic [CNT_W-1:0] x, input int k);
        logic [PW-1:0] acc;
        acc = '0;
        for (int b = 0; b < 4; b++) begin
            if (k[b]) acc = acc + (PW'(x) << b);
        end
        return acc;
    endfunction

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   s, s_prev_q, s_prev_d, rise, fall, tmo_hit, launch;
    logic [CNT_W-1:0]       cnt_q, cnt_d, hc_q, hc_d;
    logic                   v1_q, v1_d, v2_q, v2_d;
    logic [CNT_W-1:0]       cap_hc_q, cap_hc_d, cap_pc_q, cap_pc_d;
    logic [CNT_W-1:0]       cap2_hc_q, cap2_hc_d, cap2_pc_q, cap2_pc_d;
    logic [PW-1:0]          num_q, num_d;
    logic [PW-1:0]          pk_q [1:10];
    logic [PW-1:0]          pk_d [1:10];
    logic [3:0]             duty_cnt;
    logic [3:0]             duty_q, duty_d;
    logic [CNT_W-1:0]       period_q, period_d, high_q, high_d;
    logic                   valid_q, valid_d, stuck_q, stuck_d;

    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], pwm_in};
        s        = sync_q[SYNC_STAGES-1];
        s_prev_d = s;
        rise     = s & ~s_prev_q;
        fall     = ~s & s_prev_q;
        if (rise)              cnt_d = CNT_W'(1);
        else if (cnt_q == TMO) cnt_d = cnt_q;
        else                   cnt_d = cnt_q + 1'b1;
        // A stuck report is issued once; stuck_q blocks repeats while cnt stays saturated.
        tmo_hit = (cnt_q == TMO) && !rise && !fall && !stuck_q;
    end

    always_comb begin
        state_d = state_q;
        hc_d    = hc_q;
        launch  = 1'b0;
        case (state_q)
            IDLE: if (rise) state_d = HIGH;
            HIGH: if (fall) begin
                hc_d    = cnt_q;
                state_d = LOW;
            end
            LOW: if (rise) begin
                launch  = 1'b1;
                state_d = HIGH;
            end
            default: state_d = IDLE;
        endcase
        if (tmo_hit) state_d = IDLE;
    end

    always_comb begin
        v1_d      = launch;
        cap_hc_d  = hc_q;
        cap_pc_d  = cnt_q;
        v2_d      = v1_q;
        num_d     = mul_k(cap_hc_q, 10);
        cap2_hc_d = cap_hc_q;
        cap2_pc_d = cap_pc_q;
        for (int k = 1; k <= 10; k++) pk_d[k] = mul_k(cap_pc_q, k);
    end

    always_comb begin
        duty_cnt = '0;
        for (int k = 1; k <= 10; k++) begin
            if (num_q >= pk_q[k]) duty_cnt = duty_cnt + 4'd1;
        end
        valid_d  = 1'b0;
        duty_d   = duty_q;
        period_d = period_q;
        high_d   = high_q;
        stuck_d  = stuck_q;
        // A timeout report displaces a pipeline result landing in the same cycle.
        if (tmo_hit) begin
            valid_d  = 1'b1;
            stuck_d  = 1'b1;
            duty_d   = s ? 4'd10 : 4'd0;
            period_d = '0;
            high_d   = '0;
        end else if (v2_q) begin
            valid_d  = 1'b1;
            stuck_d  = 1'b0;
            duty_d   = duty_cnt;
            period_d = cap2_pc_q;
            high_d   = cap2_hc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q    <= '0;
            s_prev_q  <= 1'b0;
            state_q   <= IDLE;
            cnt_q     <= '0;
            hc_q      <= '0;
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            cap_hc_q  <= '0;
            cap_pc_q  <= '0;
            cap2_hc_q <= '0;
            cap2_pc_q <= '0;
            num_q     <= '0;
            for (int k = 1; k <= 10; k++) pk_q[k] <= '0;
            duty_q    <= '0;
            period_q  <= '0;
            high_q    <= '0;
            valid_q   <= 1'b0;
            stuck_q   <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            s_prev_q  <= s_prev_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hc_q      <= hc_d;
            v1_q      <= v1_d;
            v2_q      <= v2_d;
            cap_hc_q  <= cap_hc_d;
            cap_pc_q  <= cap_pc_d;
            cap2_hc_q <= cap2_hc_d;
            cap2_pc_q <= cap2_pc_d;
            num_q     <= num_d;
            for (int k = 1; k <= 10; k++) pk_q[k] <= pk_d[k];
            duty_q    <= duty_d;
            period_q  <= period_d;
            high_q    <= high_d;
            valid_q   <= valid_d;
            stuck_q   <= stuck_d;
        end
    end

    assign duty_tenths = duty_q;
    assign period      = period_q;
    assign high_time   = high_q;
    assign valid       = valid_q;
    assign stuck       = stuck_q;
endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Bench for pwm_duty_decoder: per-cycle scoreboard driven by an index-arithmetic model,
// table vectors, timeout/reset corner sequences and an asynchronous jitter run.
module tb_pwm_duty_decoder;
    localparam int CNT_W = 16;
    localparam int TMO   = 64;
    localparam int RW    = 1 + 4 + CNT_W + CNT_W;

    logic             clk = 1'b0;
    logic             rst;
    logic             pwm_in;
    logic [3:0]       duty_tenths;
    logic [CNT_W-1:0] period, high_time;
    logic             valid, stuck;

    pwm_duty_decoder #(.CNT_W(CNT_W), .SYNC_STAGES(2), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .pwm_in(pwm_in), .duty_tenths(duty_tenths),
        .period(period), .high_time(high_time), .valid(valid), .stuck(stuck)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Scoreboard: expected {stuck, duty, period, high} and the iteration it must appear in.
    logic [RW-1:0] exp_q[$];
    int            exp_at_q[$];
    logic [RW-1:0] o_exp;
    int            cyc = 0;
    bit            chk_en = 1'b0;
    bit            post_reset = 1'b0;

    // Model state, expressed in absolute input-sample indices.
    bit m_prev, m_armed, m_have_fall, m_stuck;
    int m_last_rise, m_last_fall;

    typedef struct {
        int hi;
        int lo;
        int duty;
        int per;
        int high;
    } vec_t;
    vec_t vecs[13];

    task automatic model_step(input bit lvl);
        bit r, f;
        int p, h;
        r = lvl & !m_prev;
        f = !lvl & m_prev;
        if (r) begin
            if (m_armed && m_have_fall) begin
                p = cyc - m_last_rise;
                h = m_last_fall - m_last_rise;
                exp_q.push_back({1'b0, 4'((10 * h) / p), CNT_W'(p), CNT_W'(h)});
                exp_at_q.push_back(cyc + 5);
                m_stuck = 1'b0;
            end
            m_armed = 1'b1;
            m_have_fall = 1'b0;
            m_last_rise = cyc;
        end else if (f) begin
            if (m_armed) begin
                m_have_fall = 1'b1;
                m_last_fall = cyc;
            end
        end else if (!m_stuck && (cyc - m_last_rise) >= TMO) begin
            exp_q.push_back({1'b1, (lvl ? 4'd10 : 4'd0), CNT_W'(0), CNT_W'(0)});
            exp_at_q.push_back(cyc + 3);
            m_stuck = 1'b1;
            m_armed = 1'b0;
            m_have_fall = 1'b0;
        end
        m_prev = lvl;
    endtask

    task automatic observe();
        logic [RW-1:0] act;
        bit exp_v;
        exp_v = 1'b0;
        if (exp_at_q.size() > 0 && exp_at_q[0] == cyc) begin
            o_exp = exp_q.pop_front();
            void'(exp_at_q.pop_front());
            exp_v = 1'b1;
        end
        act = {stuck, duty_tenths, period, high_time};
        checks++;
        if (valid !== exp_v || act !== o_exp) begin
            errors++;
            $display("FAIL cycle %0d: got valid=%0b stuck=%0b duty=%0d period=%0d high=%0d, want valid=%0b stuck=%0b duty=%0d period=%0d high=%0d",
                     cyc, valid, stuck, duty_tenths, period, high_time, exp_v,
                     o_exp[RW-1], o_exp[RW-2 -: 4], o_exp[2*CNT_W-1 -: CNT_W], o_exp[CNT_W-1:0]);
        end
        if (post_reset) begin
            post_reset = 1'b0;
            checks++;
            if ({valid, act} !== '0) begin
                errors++;
                $display("FAIL reset_state: got valid=%0b stuck=%0b duty=%0d period=%0d high=%0d, want all 0",
                         valid, stuck, duty_tenths, period, high_time);
            end
        end
    endtask

    task automatic drive_cycle(input bit lvl);
        @(negedge clk);
        if (chk_en) observe();
        rst = 1'b0;
        pwm_in = lvl;
        model_step(lvl);
        cyc++;
    endtask

    task automatic drive_wave(input int hi, input int lo, input int n);
        for (int i = 0; i < n; i++) begin
            repeat (hi) drive_cycle(1'b1);
            repeat (lo) drive_cycle(1'b0);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        if (chk_en) observe();
        rst = 1'b1;
        pwm_in = 1'b0;
        exp_q.delete();
        exp_at_q.delete();
        o_exp = '0;
        m_prev = 1'b0;
        m_armed = 1'b0;
        m_have_fall = 1'b0;
        m_stuck = 1'b0;
        m_last_rise = cyc - 1;
        cyc++;
        chk_en = 1'b1;
        post_reset = 1'b1;
    endtask

    task automatic check_now(input string name, input int d, input int p, input int h, input bit s);
        checks++;
        if ({stuck, duty_tenths, period, high_time} !== {s, 4'(d), CNT_W'(p), CNT_W'(h)}) begin
            errors++;
            $display("FAIL %s: got stuck=%0b duty=%0d period=%0d high=%0d, want stuck=%0b duty=%0d period=%0d high=%0d",
                     name, stuck, duty_tenths, period, high_time, s, d, p, h);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nval;
        vecs[0]  = '{5, 5, 5, 10, 5};
        vecs[1]  = '{3, 7, 3, 10, 3};
        vecs[2]  = '{9, 1, 9, 10, 9};
        vecs[3]  = '{7, 13, 3, 20, 7};
        vecs[4]  = '{1, 1, 5, 2, 1};
        vecs[5]  = '{1, 9, 1, 10, 1};
        vecs[6]  = '{2, 3, 4, 5, 2};
        vecs[7]  = '{10, 20, 3, 30, 10};
        vecs[8]  = '{1, 2, 3, 3, 1};
        vecs[9]  = '{13, 17, 4, 30, 13};
        vecs[10] = '{29, 30, 4, 59, 29};
        vecs[11] = '{30, 1, 9, 31, 30};
        vecs[12] = '{6, 4, 6, 10, 6};

        rst = 1'b1;
        pwm_in = 1'b0;
        repeat (3) @(negedge clk);
        do_reset();

        // Quiet line, then the table of square waves.
        repeat (20) drive_cycle(1'b0);
        for (int i = 0; i < 13; i++) begin
            drive_wave(vecs[i].hi, vecs[i].lo, 4);
            check_now($sformatf("vec%0d_%0dh_%0dl", i, vecs[i].hi, vecs[i].lo),
                      vecs[i].duty, vecs[i].per, vecs[i].high, 1'b0);
        end

        // Random waveforms, all shorter than the timeout.
        for (int i = 0; i < 24; i++) begin
            drive_wave($urandom_range(1, 30), $urandom_range(1, 30), 3);
        end

        // Stuck high, recovery, stuck low, recovery.
        drive_wave(5, 5, 3);
        repeat (80) drive_cycle(1'b1);
        check_now("stuck_high", 10, 0, 0, 1'b1);
        drive_wave(5, 5, 4);
        check_now("resume_after_high", 5, 10, 5, 1'b0);
        repeat (80) drive_cycle(1'b0);
        check_now("stuck_low", 0, 0, 0, 1'b1);
        drive_wave(5, 5, 4);
        check_now("resume_after_low", 5, 10, 5, 1'b0);

        // Rise exactly when the counter reaches the timeout wins over the timeout.
        drive_wave(5, 59, 1);
        repeat (5) drive_cycle(1'b1);
        repeat (6) drive_cycle(1'b0);
        check_now("edge_at_timeout", 0, 64, 5, 1'b0);

        // One cycle longer: the timeout fires in the low phase.
        drive_wave(5, 60, 1);
        repeat (5) drive_cycle(1'b1);
        check_now("timeout_period_65", 0, 0, 0, 1'b1);
        drive_wave(5, 5, 4);
        check_now("resume_after_65", 5, 10, 5, 1'b0);

        // Reset in the middle of a high phase.
        drive_wave(5, 5, 3);
        repeat (2) drive_cycle(1'b1);
        do_reset();
        drive_wave(5, 5, 3);
        check_now("after_mid_reset", 5, 10, 5, 1'b0);

        // Dead source straight after reset.
        do_reset();
        repeat (70) drive_cycle(1'b0);
        check_now("dead_source", 0, 0, 0, 1'b1);

        // Asynchronous jitter: nominal 6 high / 6 low, edges off the clock grid.
        do_reset();
        @(negedge clk);
        chk_en = 1'b0;
        rst = 1'b0;
        nval = 0;
        fork
            begin
                longint base;
                int off;
                base = $time;
                for (int k = 0; k < 30; k++) begin
                    off = $urandom_range(0, 9);
                    if (off == 5) off = 4;
                    #((base + 120 * k + off) - $time) pwm_in = 1'b1;
                    off = $urandom_range(0, 9);
                    if (off == 5) off = 4;
                    #((base + 120 * k + 60 + off) - $time) pwm_in = 1'b0;
                end
            end
            begin
                repeat (380) begin
                    @(negedge clk);
                    if (valid === 1'b1) begin
                        nval++;
                        checks++;
                        if (period < 11 || period > 13 || high_time < 5 || high_time > 7 || stuck !== 1'b0) begin
                            errors++;
                            $display("FAIL jitter_meas: got period=%0d high=%0d stuck=%0b, want period 11..13 high 5..7 stuck 0",
                                     period, high_time, stuck);
                        end
                    end
                end
            end
        join
        checks++;
        if (nval < 20) begin
            errors++;
            $display("FAIL jitter_count: got %0d results, want at least 20", nval);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
